// File: rtl/aqfp_pkg.sv
// Shared AQFP four-valued logic type and helpers for the majority pipeline.
// Encoding: q0=00, q1=01, qX=10, qZ=11 (bit1 set means non-binary).
package aqfp_pkg;

    typedef enum logic [1:0] {
        Q0 = 2'b00,
        Q1 = 2'b01,
        QX = 2'b10,
        QZ = 2'b11
    } logic_aqfp_t;

    // Inversion only swaps binary values; unknowns pass through untouched.
    function automatic logic_aqfp_t aqfp_inv(input logic_aqfp_t v, input logic en);
        logic_aqfp_t r;
        r = v;
        if (en) begin
            case (v)
                Q0:      r = Q1;
                Q1:      r = Q0;
                default: r = v;
            endcase
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic aqfp_is_binary(input logic_aqfp_t v);
        return (v == Q0) || (v == Q1);
    endfunction

endpackage

// File: rtl/aqfp_maj_pipe_if.sv
// Bus bundle for aqfp_maj_pipe: input beat, output beat and counter control.
interface aqfp_maj_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic                 in_valid;
    logic [2*WIDTH-1:0]   a;
    logic [2*WIDTH-1:0]   b;
    logic [2*WIDTH-1:0]   c;
    logic                 clr_count;
    logic                 out_valid;
    logic [2*WIDTH-1:0]   out;
    logic [CNT_W-1:0]     z_count;

    modport master (
        output in_valid, a, b, c, clr_count,
        input  out_valid, out, z_count
    );

    modport slave (
        input  in_valid, a, b, c, clr_count,
        output out_valid, out, z_count
    );
endinterface

// File: rtl/aqfp_maj3_cell.sv
// Single-lane combinational 3-input AQFP majority with static input inversion.
// Unknown handling is selected by the AQFP_XPROP_EN macro.
module aqfp_maj3_cell
    import aqfp_pkg::*;
#(
    parameter bit INV_A = 1'b0,
    parameter bit INV_B = 1'b0,
    parameter bit INV_C = 1'b0
) (
    input  logic_aqfp_t a,
    input  logic_aqfp_t b,
    input  logic_aqfp_t c,
    output logic_aqfp_t y
);

    logic_aqfp_t a_s;
    logic_aqfp_t b_s;
    logic_aqfp_t c_s;
    logic        any_x_s;
    logic        any_z_s;
    logic        maj_s;

    // Invert operands, classify unknowns and resolve the vote.
    always_comb begin
        a_s     = aqfp_inv(a, INV_A);
        b_s     = aqfp_inv(b, INV_B);
        c_s     = aqfp_inv(c, INV_C);
        any_x_s = (a_s == QX) || (b_s == QX) || (c_s == QX);
        any_z_s = (a_s == QZ) || (b_s == QZ) || (c_s == QZ);
        maj_s   = ((a_s == Q1) && (b_s == Q1)) ||
                  ((a_s == Q1) && (c_s == Q1)) ||
                  ((b_s == Q1) && (c_s == Q1));
        y       = QZ;
`ifdef AQFP_XPROP_EN
        if (any_x_s) begin
            y = QX;
        end else if (any_z_s) begin
            y = QZ;
        end else begin
            y = maj_s ? Q1 : Q0;
        end
`else
        if (any_x_s || any_z_s) begin
            y = QZ;
        end else begin
            y = maj_s ? Q1 : Q0;
        end
`endif
    end

endmodule

// File: rtl/aqfp_maj_pipe.sv
// WIDTH-lane AQFP majority followed by a DEPTH-stage balancing pipeline and a
// saturating non-binary beat counter. Optional macro: AQFP_XPROP_EN.
module aqfp_maj_pipe
    import aqfp_pkg::*;
#(
    parameter int         WIDTH    = 8,
    parameter int         DEPTH    = 2,
    parameter logic [2:0] INV_MASK = 3'b000,
    parameter int         CNT_W    = 8
) (
    input  logic           clkin,
    input  logic           rst,
    aqfp_maj_pipe_if.slave bus
);

    localparam int               DW      = 2 * WIDTH;
    localparam logic [DW-1:0]    ALL_Z   = {WIDTH{2'b11}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DW-1:0]    vote_s;
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             out_nonbin_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic_aqfp_t lane_y;

        aqfp_maj3_cell #(
            .INV_A (INV_MASK[2]),
            .INV_B (INV_MASK[1]),
            .INV_C (INV_MASK[0])
        ) u_cell (
            .a (logic_aqfp_t'(bus.a[2*i +: 2])),
            .b (logic_aqfp_t'(bus.b[2*i +: 2])),
            .c (logic_aqfp_t'(bus.c[2*i +: 2])),
            .y (lane_y)
        );

        assign vote_s[2*i +: 2] = lane_y;
    end

    // Stage 1 captures the vote or an unexcited all-qZ bubble; later stages shift.
    always_comb begin
        vld_d = '0;
        for (int s = 0; s < DEPTH; s++) begin
            data_d[s] = ALL_Z;
        end
        if (bus.in_valid) begin
            vld_d[0]  = 1'b1;
            data_d[0] = vote_s;
        end else begin
            vld_d[0]  = 1'b0;
            data_d[0] = ALL_Z;
        end
        for (int s = 1; s < DEPTH; s++) begin
            data_d[s] = data_q[s-1];
            vld_d[s]  = vld_q[s-1];
        end
    end

    // Any lane with bit1 set on the registered output is qX or qZ.
    always_comb begin
        out_nonbin_s = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (data_q[DEPTH-1][2*i+1]) begin
                out_nonbin_s = 1'b1;
            end else begin
                out_nonbin_s = out_nonbin_s;
            end
        end
    end

    // Clear wins over increment; increment holds once saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr_count) begin
            cnt_d = '0;
        end else if (vld_q[DEPTH-1] && out_nonbin_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pipeline and counter state; reset flushes every in-flight beat.
    always_ff @(posedge clkin) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                data_q[s] <= ALL_Z;
            end
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                data_q[s] <= data_d[s];
            end
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.out       = data_q[DEPTH-1];
    assign bus.out_valid = vld_q[DEPTH-1];
    assign bus.z_count   = cnt_q;

endmodule
